// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding word fetch at a
// time, parks a response in a one-entry skid buffer when decode is stalled,
// squashes in-flight fetches on EX redirects and traps misaligned targets.

package if_stage_pkg;
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        valid;
   } if_id_reg_t;
endpackage

module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output if_id_reg_t  if_id_reg,
   output logic        fetch_fault
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [1:0] FAULT = 2'd3;

   logic [1:0]  state;
   logic [63:0] pc;
   logic [63:0] inflight_pc;
   logic [63:0] skid_pc;
   logic [31:0] skid_instr;
   logic        discard;     // next response belongs to a squashed fetch

   logic slot_free;
   logic rsp_take;
   logic accept;
   logic owed;

   // Request generation: FETCH always asks; WAIT asks again only in the cycle a
   // live response drains into if_id, giving one instruction per cycle.
   always_comb begin
      slot_free      = !if_id_reg.valid || !stall;
      rsp_take       = (state == WAIT) && imem_rsp_valid && !discard && slot_free;
      imem_req_valid = !rst && ((state == FETCH) || (rsp_take && !redirect_valid));
      imem_req_addr  = pc;
      accept         = imem_req_valid && imem_req_ready;
      // A response is still owed to us after this cycle if one is in flight and
      // not arriving now; a redirect must then discard it.
      owed = ((state == WAIT)  && !imem_rsp_valid) ||
             ((state == FETCH) && accept) ||
             ((state == FAULT) && discard && !imem_rsp_valid);
   end

   // Fetch FSM, PC, skid buffer and if_id register; redirect overrides stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         inflight_pc <= '0;
         skid_pc     <= '0;
         skid_instr  <= '0;
         discard     <= 1'b0;
         fetch_fault <= 1'b0;
         if_id_reg   <= '0;
      end else if (redirect_valid) begin
         if_id_reg.valid <= 1'b0;
         pc              <= redirect_pc;
         discard         <= owed;
         if (redirect_pc[1:0] != 2'b00) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
         end else begin
            state       <= owed ? WAIT : FETCH;
            fetch_fault <= 1'b0;
         end
      end else begin
         case (state)
            FETCH: begin
               if (!stall) if_id_reg.valid <= 1'b0;
               if (accept) begin
                  inflight_pc <= pc;
                  pc          <= pc + 64'd4;
                  state       <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rsp_valid && discard) begin
                  discard <= 1'b0;
                  state   <= FETCH;
                  if (!stall) if_id_reg.valid <= 1'b0;
               end else if (imem_rsp_valid && slot_free) begin
                  if_id_reg <= {inflight_pc, imem_rsp_data, 1'b1};
                  if (accept) begin
                     inflight_pc <= pc;
                     pc          <= pc + 64'd4;
                  end else begin
                     state <= FETCH;
                  end
               end else if (imem_rsp_valid) begin
                  skid_pc    <= inflight_pc;
                  skid_instr <= imem_rsp_data;
                  state      <= HOLD;
               end else if (!stall) begin
                  if_id_reg.valid <= 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  if_id_reg <= {skid_pc, skid_instr, 1'b1};
                  state     <= FETCH;
               end
            end
            default: begin
               // FAULT: swallow any squashed response still on its way.
               if_id_reg.valid <= 1'b0;
               if (imem_rsp_valid) discard <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run checked against
// an architectural stream model (sequential PCs from the last redirect target,
// instruction = pure function of address) and a single-outstanding memory model.
module tb_if_stage;
   import if_stage_pkg::*;

   localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   if_id_reg_t  if_id_reg;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   int          lat_min, lat_max;
   bit          mem_busy;
   logic [63:0] mem_addr;
   int          mem_cnt;
   logic [63:0] exp_pc;
   int          delivered;

   if_stage #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_id_reg(if_id_reg),
      .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [31:0] memfn(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0000_0013;
   endfunction

   // One clock: sample pre-edge, advance, update stream model and memory.
   task automatic tick();
      bit          acc, cons, rdv, rspn;
      logic [63:0] a, cpc, rpc;
      logic [31:0] cins;
      #1;
      acc  = imem_req_valid && imem_req_ready;
      a    = imem_req_addr;
      cons = if_id_reg.valid && !stall;
      cpc  = if_id_reg.pc;
      cins = if_id_reg.instr;
      rdv  = redirect_valid;
      rpc  = redirect_pc;
      rspn = imem_rsp_valid;
      @(posedge clk);
      #1;
      if (rst) begin
         mem_busy       = 1'b0;
         imem_rsp_valid = 1'b0;
         return;
      end
      if (cons) begin
         checks++;
         if (cpc !== exp_pc || cins !== memfn(cpc)) begin
            errors++;
            $display("FAIL stream: got pc %h instr %h, want pc %h instr %h",
                     cpc, cins, exp_pc, memfn(exp_pc));
         end
         exp_pc = exp_pc + 64'd4;
         delivered++;
      end
      if (rdv) exp_pc = rpc;
      if (rspn) mem_busy = 1'b0;
      if (acc) begin
         checks++;
         if (mem_busy || a[1:0] != 2'b00) begin
            errors++;
            $display("FAIL accept: busy %0d addr %h, want idle and aligned", mem_busy, a);
         end
         mem_busy = 1'b1;
         mem_addr = a;
         mem_cnt  = $urandom_range(lat_max, lat_min);
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mem_busy) begin
         if (mem_cnt <= 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mem_addr);
         end else begin
            mem_cnt--;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      mem_busy = 1'b0; lat_min = 1; lat_max = 1; delivered = 0;
      tick();
      tick();
      rst = 1'b0;
      exp_pc = RPC;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic wait_if_id(input logic [63:0] want_pc);
      int n = 0;
      while (!if_id_reg.valid && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!if_id_reg.valid || if_id_reg.pc !== want_pc || if_id_reg.instr !== memfn(want_pc)) begin
         errors++;
         $display("FAIL wait_if_id: got valid %0d pc %h, want pc %h", if_id_reg.valid, if_id_reg.pc, want_pc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
      redirect_pc = '0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      #1;
      chk("reset_req_valid", 64'(imem_req_valid), 64'd0);
      chk("reset_if_id_valid", 64'(if_id_reg.valid), 64'd0);
      chk("reset_fault", 64'(fetch_fault), 64'd0);
      do_reset();
      #1;
      chk("reset_first_req_valid", 64'(imem_req_valid), 64'd1);
      chk("reset_first_addr", imem_req_addr, RPC);
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("stream_req_valid", 64'(imem_req_valid), 64'd1);
         chk("stream_addr", imem_req_addr, RPC + 64'(4 * i));
         if (i >= 2) begin
            chk("stream_if_valid", 64'(if_id_reg.valid), 64'd1);
            chk("stream_if_pc", if_id_reg.pc, RPC + 64'(4 * (i - 2)));
            chk("stream_if_instr", 64'(if_id_reg.instr), 64'(memfn(RPC + 64'(4 * (i - 2)))));
         end
         tick();
      end
   endtask

   task automatic test_stall();
      int rv[10], ra[10], iv[10], ipc[10];
      rv  = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
      ra  = '{0, 4, 8, -1, -1, -1, -1, 12, 16, 20};
      iv  = '{0, 0, 1, 1, 1, 1, 1, 1, 0, 1};
      ipc = '{-1, -1, 0, 4, 4, 4, 4, 8, -1, 12};
      do_reset();
      for (int c = 0; c < 10; c++) begin
         stall = (c >= 3 && c <= 5);
         #1;
         chk("stall_req_valid", 64'(imem_req_valid), 64'(rv[c]));
         if (ra[c] >= 0) chk("stall_addr", imem_req_addr, RPC + 64'(ra[c]));
         chk("stall_if_valid", 64'(if_id_reg.valid), 64'(iv[c]));
         if (ipc[c] >= 0) chk("stall_if_pc", if_id_reg.pc, RPC + 64'(ipc[c]));
         tick();
      end
      stall = 1'b0;
   endtask

   task automatic test_redirect_wait();
      do_reset();
      lat_min = 3; lat_max = 3;
      #1;
      chk("rdw_first_addr", imem_req_addr, RPC);
      tick();
      redirect_valid = 1'b1; redirect_pc = RPC + 64'h100;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("rdw_c2_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rdw_c2_if_valid", 64'(if_id_reg.valid), 64'd0);
      tick();
      #1;
      chk("rdw_stale_rsp_present", 64'(imem_rsp_valid), 64'd1);
      chk("rdw_c3_req_valid", 64'(imem_req_valid), 64'd0);
      tick();
      #1;
      chk("rdw_c4_req_valid", 64'(imem_req_valid), 64'd1);
      chk("rdw_c4_addr", imem_req_addr, RPC + 64'h100);
      chk("rdw_c4_if_valid", 64'(if_id_reg.valid), 64'd0);
      wait_if_id(RPC + 64'h100);
   endtask

   task automatic test_redirect_rsp_stall();
      do_reset();
      tick();
      tick();
      stall = 1'b1; redirect_valid = 1'b1; redirect_pc = RPC + 64'h300;
      #1;
      chk("rrs_rsp_coincident", 64'(imem_rsp_valid), 64'd1);
      chk("rrs_if_valid_before", 64'(if_id_reg.valid), 64'd1);
      tick();
      stall = 1'b0; redirect_valid = 1'b0;
      #1;
      chk("rrs_if_valid_after", 64'(if_id_reg.valid), 64'd0);
      chk("rrs_req_valid", 64'(imem_req_valid), 64'd1);
      chk("rrs_addr", imem_req_addr, RPC + 64'h300);
      tick();
      wait_if_id(RPC + 64'h300);
   endtask

   task automatic test_fault();
      do_reset();
      lat_min = 3; lat_max = 3;
      redirect_valid = 1'b1; redirect_pc = RPC + 64'h102;
      tick();
      redirect_valid = 1'b0;
      for (int c = 1; c <= 2; c++) begin
         #1;
         chk("fault_flag", 64'(fetch_fault), 64'd1);
         chk("fault_req_valid", 64'(imem_req_valid), 64'd0);
         chk("fault_if_valid", 64'(if_id_reg.valid), 64'd0);
         if (c == 2) begin
            redirect_valid = 1'b1; redirect_pc = RPC + 64'h200;
         end
         tick();
      end
      redirect_valid = 1'b0;
      #1;
      chk("fault_cleared", 64'(fetch_fault), 64'd0);
      chk("fault_owed_rsp_dropped_req", 64'(imem_req_valid), 64'd0);
      tick();
      #1;
      chk("fault_resume_valid", 64'(imem_req_valid), 64'd1);
      chk("fault_resume_addr", imem_req_addr, RPC + 64'h200);
      wait_if_id(RPC + 64'h200);
   endtask

   task automatic test_rst_mid();
      do_reset();
      lat_min = 3; lat_max = 3;
      tick();
      rst = 1'b1; imem_rsp_valid = 1'b0; mem_busy = 1'b0;
      #1;
      chk("rstmid_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rstmid_if_valid", 64'(if_id_reg.valid), 64'd0);
      tick();
      rst = 1'b0;
      exp_pc = RPC;
      #1;
      chk("rstmid_release_valid", 64'(imem_req_valid), 64'd1);
      chk("rstmid_release_addr", imem_req_addr, RPC);
      lat_min = 1; lat_max = 1;
      tick();
      wait_if_id(RPC);
   endtask

   task automatic test_random();
      do_reset();
      lat_min = 1; lat_max = 3;
      for (int c = 0; c < 600; c++) begin
         stall          = ($urandom % 10) < 3;
         imem_req_ready = ($urandom % 10) < 7;
         redirect_valid = ($urandom % 100) < 4;
         if ($urandom % 8 == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
         else redirect_pc = RPC + {52'd0, 10'($urandom_range(0, 1023)), 2'b00};
         tick();
      end
      redirect_valid = 1'b0; stall = 1'b0; imem_req_ready = 1'b1;
      checks++;
      if (delivered < 60) begin
         errors++;
         $display("FAIL random_throughput: delivered %0d, want at least 60", delivered);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_wait();
      test_redirect_rsp_stall();
      test_fault();
      test_rst_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
